// File: rtl/dmem_if.sv
// Load/store channel between the datapath and the data-memory responder.
// A beat transfers on a rising edge where valid && ready; the initiator holds valid
// and its payload stable until that beat, and ready never depends on valid.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_read, req_write, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_read, req_write, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target with programmable wait states, byte-lane stores,
// sign/zero-extended loads and error flagging for malformed or out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   a_addr, a_wdata;
  logic          a_read, a_write, a_unsigned;
  logic [1:0]    a_size;
  logic [63:0]   mem [DEPTH];

  logic          accept, commit;
  logic [63:0]   c_addr, c_wdata;
  logic          c_read, c_write, c_unsigned;
  logic [1:0]    c_size;
  logic [AW-1:0] c_idx;
  logic [5:0]    c_shift;
  logic [63:0]   c_mask, c_old, c_field, c_load, c_store, c_rdata;
  logic          c_misalign, c_oor, c_err, c_sign;

  assign accept    = bus.req_valid && bus.req_ready;
  // With zero wait states the accept edge is also the commit edge.
  assign commit    = ((state == S_IDLE) && accept && (LATENCY == 0)) ||
                     ((state == S_BUSY) && (cnt == '0));
  assign dbg_state = state;

  always_comb begin
    c_addr     = (state == S_IDLE) ? bus.req_addr     : a_addr;
    c_wdata    = (state == S_IDLE) ? bus.req_wdata    : a_wdata;
    c_read     = (state == S_IDLE) ? bus.req_read     : a_read;
    c_write    = (state == S_IDLE) ? bus.req_write    : a_write;
    c_size     = (state == S_IDLE) ? bus.req_size     : a_size;
    c_unsigned = (state == S_IDLE) ? bus.req_unsigned : a_unsigned;
    c_idx      = c_addr[AW+2:3];
    c_shift    = {c_addr[2:0], 3'b000};
    case (c_size)
      2'd0:    begin c_mask = 64'h0000_0000_0000_00FF; c_misalign = 1'b0;          end
      2'd1:    begin c_mask = 64'h0000_0000_0000_FFFF; c_misalign = c_addr[0];     end
      2'd2:    begin c_mask = 64'h0000_0000_FFFF_FFFF; c_misalign = |c_addr[1:0]; end
      default: begin c_mask = 64'hFFFF_FFFF_FFFF_FFFF; c_misalign = |c_addr[2:0]; end
    endcase
    c_oor   = (c_addr[63:3] >= 61'(DEPTH));
    c_err   = (c_read == c_write) || c_misalign || c_oor;
    c_old   = mem[c_idx];
    c_field = (c_old >> c_shift) & c_mask;
    // The top bit of the mask picks the field's sign bit for every size.
    c_sign  = !c_unsigned && (|(c_field & (c_mask ^ (c_mask >> 1))));
    c_load  = c_sign ? (c_field | ~c_mask) : c_field;
    c_store = (c_old & ~(c_mask << c_shift)) | ((c_wdata & c_mask) << c_shift);
    c_rdata = (c_err || !c_read) ? 64'd0 : c_load;
  end

  always_ff @(posedge clk) begin
    if (reset && commit && c_write && !c_err) mem[c_idx] <= c_store;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 64'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_addr        <= bus.req_addr;
            a_wdata       <= bus.req_wdata;
            a_read        <= bus.req_read;
            a_write       <= bus.req_write;
            a_size        <= bus.req_size;
            a_unsigned    <= bus.req_unsigned;
            bus.req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= c_rdata;
              bus.rsp_err   <= c_err;
            end else begin
              state <= S_BUSY;
              cnt   <= CW'(LATENCY > 0 ? LATENCY - 1 : 0);
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= c_rdata;
            bus.rsp_err   <= c_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 64'd0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance (index 0) and a LATENCY=0 instance
// (index 1), each checked every cycle against a byte-array transaction model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, req_valid, req_read, req_write, req_unsigned, rsp_ready, rsp_hold, stall_en;
  logic [63:0] req_addr [2];
  logic [63:0] req_wdata [2];
  logic [1:0]  req_size [2];
  wire  [1:0]  dbg_a, dbg_b;

  dmem_if bus_a ();
  dmem_if bus_b ();

  assign bus_a.req_valid = req_valid[0];    assign bus_b.req_valid = req_valid[1];
  assign bus_a.req_addr = req_addr[0];      assign bus_b.req_addr = req_addr[1];
  assign bus_a.req_wdata = req_wdata[0];    assign bus_b.req_wdata = req_wdata[1];
  assign bus_a.req_read = req_read[0];      assign bus_b.req_read = req_read[1];
  assign bus_a.req_write = req_write[0];    assign bus_b.req_write = req_write[1];
  assign bus_a.req_size = req_size[0];      assign bus_b.req_size = req_size[1];
  assign bus_a.req_unsigned = req_unsigned[0]; assign bus_b.req_unsigned = req_unsigned[1];
  assign bus_a.rsp_ready = rsp_ready[0];    assign bus_b.rsp_ready = rsp_ready[1];

  wire [1:0]  o_req_ready = {bus_b.req_ready, bus_a.req_ready};
  wire [1:0]  o_rsp_valid = {bus_b.rsp_valid, bus_a.rsp_valid};
  wire [1:0]  o_rsp_err   = {bus_b.rsp_err, bus_a.rsp_err};
  wire [63:0] o_rsp_rdata [2];
  assign o_rsp_rdata[0] = bus_a.rsp_rdata;
  assign o_rsp_rdata[1] = bus_b.rsp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst_n[0]), .bus(bus_a.slave), .dbg_state(dbg_a));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst_n[1]), .bus(bus_b.slave), .dbg_state(dbg_b));

  int  checks = 0;
  int  errors = 0;
  time acc_t [2];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [63:0] w_pat(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h5A5A0000 | 32'(i)};
  endfunction

  // rsp_ready: random back-pressure when stall_en, otherwise the level in rsp_hold.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++)
      rsp_ready[k] = stall_en[k] ? ($urandom_range(0, 3) != 0) : rsp_hold[k];
  end

  // ---------------- behavioural model ----------------
  logic [7:0]  mdl_mem [2][NB];
  logic        live [2], e_ready [2], e_valid [2], e_err [2], chk_clr [2];
  logic [63:0] e_rdata [2];
  int          left [2];
  logic [63:0] p_addr [2], p_wdata [2];
  logic        p_rd [2], p_wr [2], p_uns [2];
  logic [1:0]  p_size [2];

  task automatic model_resp(input int k);
    int n, a;
    logic bad;
    logic [63:0] v;
    n   = 1 << p_size[k];
    bad = (p_rd[k] == p_wr[k]) || ((p_addr[k] % 64'(n)) != 0) || ((p_addr[k] >> 3) >= 64'(DEPTH));
    a   = int'(p_addr[k][15:0]);
    e_valid[k] = 1'b1;
    e_err[k]   = bad;
    e_rdata[k] = 64'd0;
    if (!bad && p_wr[k])
      for (int i = 0; i < n; i++) mdl_mem[k][a + i] = p_wdata[k][8*i +: 8];
    if (!bad && p_rd[k]) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_mem[k][a + i];
      if (!p_uns[k] && n < 8 && v[8*n-1])
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e_rdata[k] = v;
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        chk("req_ready", k, 64'(o_req_ready[k]), 64'(e_ready[k]));
        chk("rsp_valid", k, 64'(o_rsp_valid[k]), 64'(e_valid[k]));
        if (e_valid[k] || chk_clr[k]) begin
          chk("rsp_rdata", k, o_rsp_rdata[k], e_rdata[k]);
          chk("rsp_err", k, 64'(o_rsp_err[k]), 64'(e_err[k]));
        end
      end
      chk_clr[k] = 1'b0;
      if (!rst_n[k]) begin
        e_ready[k] = 1'b0; e_valid[k] = 1'b0; e_rdata[k] = 64'd0; e_err[k] = 1'b0;
        left[k] = 0; chk_clr[k] = 1'b1; live[k] = 1'b1;
      end else if (e_valid[k]) begin
        if (rsp_ready[k]) begin e_valid[k] = 1'b0; e_ready[k] = 1'b1; end
      end else if (left[k] > 0) begin
        left[k]--;
        if (left[k] == 0) model_resp(k);
      end else if (e_ready[k] && req_valid[k]) begin
        p_addr[k] = req_addr[k]; p_wdata[k] = req_wdata[k]; p_rd[k] = req_read[k];
        p_wr[k] = req_write[k]; p_size[k] = req_size[k]; p_uns[k] = req_unsigned[k];
        e_ready[k] = 1'b0;
        left[k] = lat_of(k);
        if (left[k] == 0) model_resp(k);
      end else begin
        e_ready[k] = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic rd, input logic wr, input logic [1:0] size, input logic uns);
    req_addr[k] = addr; req_wdata[k] = wdata; req_read[k] = rd;
    req_write[k] = wr; req_size[k] = size; req_unsigned[k] = uns;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL accept_timeout u%0d: got no req_ready required req_ready=1", k); end
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!o_rsp_valid[k] && lat < 50);
    if (lat >= 50) begin checks++; errors++; $display("FAIL rsp_timeout u%0d: got no rsp_valid required rsp_valid=1", k); end
  endtask

  task automatic xact(input int k, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                      output logic [63:0] rdata, output logic err, output int lat);
    int n;
    @(posedge clk); #1;
    set_req(k, addr, wdata, rd, wr, size, uns);
    req_valid[k] = 1'b1;
    wait_ready(k);
    @(posedge clk);
    acc_t[k] = $time;
    #1 req_valid[k] = 1'b0;
    wait_rsp(k, lat);
    rdata = o_rsp_rdata[k];
    err   = o_rsp_err[k];
    n = 0;
    while (!rsp_ready[k] && n < 50) begin @(negedge clk); n++; end
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] r;
  logic        e;
  int          lat;
  time         prev_t;

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 2'b00; req_valid = 2'b00; rsp_hold = 2'b11; stall_en = 2'b00;
    req_read = 2'b00; req_write = 2'b00; req_unsigned = 2'b00;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0);
      live[k] = 1'b0; e_ready[k] = 1'b0; e_valid[k] = 1'b0; e_err[k] = 1'b0;
      e_rdata[k] = 64'd0; chk_clr[k] = 1'b0; left[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 2'b11;
    @(negedge clk); chk("ready_in_release_cycle", 0, 64'(o_req_ready[0]), 64'd0);
    @(negedge clk); chk("ready_after_release", 0, 64'(o_req_ready[0]), 64'd1);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) xact(k, 64'(i * 8), w_pat(i), 1'b0, 1'b1, 2'd3, 1'b0, r, e, lat);

    for (int k = 0; k < 2; k++) begin
      xact(k, 64'h10, 64'h1122334455667788, 1'b0, 1'b1, 2'd3, 1'b0, r, e, lat);
      chk("store_lat", k, 64'(lat), 64'(lat_of(k) + 1)); chk("store_rdata", k, r, 64'd0); chk("store_err", k, 64'(e), 64'd0);
      xact(k, 64'h10, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat);
      chk("load_lat", k, 64'(lat), 64'(lat_of(k) + 1)); chk("load_dbl", k, r, 64'h1122334455667788); chk("load_err", k, 64'(e), 64'd0);
      xact(k, 64'h13, 64'h00000000000000F0, 1'b0, 1'b1, 2'd0, 1'b0, r, e, lat);
      xact(k, 64'h13, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, r, e, lat); chk("load_b_signed", k, r, 64'hFFFFFFFFFFFFFFF0);
      xact(k, 64'h13, 64'd0, 1'b1, 1'b0, 2'd0, 1'b1, r, e, lat); chk("load_b_unsigned", k, r, 64'h00000000000000F0);
      xact(k, 64'h10, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat); chk("load_dbl_merged", k, r, 64'h11223344F0667788);
      xact(k, 64'h11, 64'd0, 1'b1, 1'b0, 2'd1, 1'b0, r, e, lat); chk("misalign_err", k, 64'(e), 64'd1); chk("misalign_rdata", k, r, 64'd0);
      xact(k, 64'(DEPTH * 8), 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat); chk("range_err", k, 64'(e), 64'd1); chk("range_rdata", k, r, 64'd0);
      xact(k, 64'h10, 64'hDEAD, 1'b1, 1'b1, 2'd3, 1'b0, r, e, lat); chk("rdwr_err", k, 64'(e), 64'd1); chk("rdwr_rdata", k, r, 64'd0);
      xact(k, 64'h10, 64'hBEEF, 1'b0, 1'b0, 2'd3, 1'b0, r, e, lat); chk("nocmd_err", k, 64'(e), 64'd1);
      xact(k, 64'h10, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat); chk("mem_unchanged", k, r, 64'h11223344F0667788);
    end

    // Response held under back-pressure while a second request waits.
    @(posedge clk); #1;
    rsp_hold[0] = 1'b0;
    set_req(0, 64'h18, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    set_req(0, 64'h08, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0);
    wait_rsp(0, lat);
    chk("hold_first_lat", 0, 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 0, 64'(o_rsp_valid[0]), 64'd1);
      chk("hold_rdata", 0, o_rsp_rdata[0], 64'hC0DE0003_5A5A0003);
      chk("hold_err", 0, 64'(o_rsp_err[0]), 64'd0);
      chk("hold_req_ready", 0, 64'(o_req_ready[0]), 64'd0);
    end
    @(posedge clk); #1 rsp_hold[0] = 1'b1;
    @(negedge clk); chk("pre_hs_valid", 0, 64'(o_rsp_valid[0]), 64'd1); chk("pre_hs_ready", 0, 64'(o_req_ready[0]), 64'd0);
    @(negedge clk); chk("post_hs_valid", 0, 64'(o_rsp_valid[0]), 64'd0); chk("post_hs_ready", 0, 64'(o_req_ready[0]), 64'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    chk("held_req_lat", 0, 64'(lat), 64'd3);
    chk("held_req_rdata", 0, o_rsp_rdata[0], 64'hC0DE0001_5A5A0001);

    // Reset while the store is still waiting: it must never land.
    @(posedge clk); #1;
    set_req(0, 64'h20, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b1, 2'd3, 1'b0);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", 0, 64'(o_rsp_valid[0]), 64'd0); chk("rst_rdata", 0, o_rsp_rdata[0], 64'd0);
    chk("rst_err", 0, 64'(o_rsp_err[0]), 64'd0); chk("rst_ready", 0, 64'(o_req_ready[0]), 64'd0);
    @(posedge clk); #1 rst_n[0] = 1'b1;
    xact(0, 64'h20, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat);
    chk("aborted_store", 0, r, 64'hC0DE0004_5A5A0004);

    // Zero-latency instance, back-to-back with rsp_ready high.
    prev_t = 0;
    for (int j = 0; j < 6; j++) begin
      xact(1, 64'(8 * j), 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, r, e, lat);
      chk("lat0_latency", 1, 64'(lat), 64'd1);
      if (j > 0) chk("lat0_spacing", 1, 64'(acc_t[1] - prev_t), 64'd20);
      prev_t = acc_t[1];
    end

    for (int k = 0; k < 2; k++) begin
      stall_en[k] = 1'b1;
      repeat (150) begin
        int sel, c;
        logic [1:0]  sz;
        logic [63:0] ad;
        logic        rd, wr;
        sel = $urandom_range(0, 19);
        sz  = 2'($urandom_range(0, 3));
        if (sel == 0)      ad = 64'(DEPTH * 8 + $urandom_range(0, 7));
        else if (sel == 1) ad = {$urandom, $urandom};
        else begin
          ad = 64'($urandom_range(0, 63));
          if ($urandom_range(0, 1) == 1) ad = ad & ~64'((1 << sz) - 1);
        end
        c = $urandom_range(0, 9);
        if (c == 0)      begin rd = 1'b1; wr = 1'b1; end
        else if (c == 1) begin rd = 1'b0; wr = 1'b0; end
        else begin rd = 1'($urandom_range(0, 1)); wr = !rd; end
        xact(k, ad, {$urandom, $urandom}, rd, wr, sz, 1'($urandom_range(0, 1)), r, e, lat);
      end
      stall_en[k] = 1'b0;
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
